// File: rtl/pipe_valid_chain.sv
// pipe_valid_chain: parametrised valid/allowin pipeline with per-stage hold, flush, occupancy and stall counter
module pipe_valid_chain #(
  parameter int STAGES = 5,
  parameter int WIDTH  = 32,
  parameter int CNTW   = 32,
  localparam int OCCW  = $clog2(STAGES + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_allowin,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [STAGES-1:0]         stage_hold,
  input  logic [STAGES-1:0]         flush_mask,
  output logic                      out_valid,
  input  logic                      out_allowin,
  output logic [WIDTH-1:0]          out_data,
  output logic [STAGES-1:0]         stage_valid,
  output logic [STAGES*WIDTH-1:0]   stage_data,
  output logic [OCCW-1:0]           occupancy,
  output logic [CNTW-1:0]           stall_cnt
);
  logic [STAGES:0]              allowin;
  logic [STAGES-1:0]            go, valid_q, valid_d, inc_valid;
  logic [STAGES*WIDTH-1:0]      data_q, data_d, inc_data;
  logic [CNTW-1:0]              stall_q, stall_d;
  always_comb begin
    allowin[STAGES] = out_allowin;
    for (int i = STAGES - 1; i >= 0; i--)
      allowin[i] = ~valid_q[i] | (~stage_hold[i] & allowin[i+1]) | flush_mask[i];
  end
  assign go        = valid_q & ~stage_hold & ~flush_mask;
  // Stage i is fed by stage i-1; stage 0 by the upstream port.
  assign inc_valid = {go[STAGES-2:0], in_valid};
  assign inc_data  = {data_q[(STAGES-1)*WIDTH-1:0], in_data};
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int i = 0; i < STAGES; i++) begin
      valid_d[i] = flush_mask[i] ? 1'b0 : allowin[i] ? inc_valid[i] : valid_q[i];
      data_d[i*WIDTH +: WIDTH] = (~flush_mask[i] & allowin[i] & inc_valid[i]) ?
                                 inc_data[i*WIDTH +: WIDTH] : data_q[i*WIDTH +: WIDTH];
    end
  end
  assign stall_d = (in_valid & ~allowin[0] & ~&stall_q) ? stall_q + CNTW'(1) : stall_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      data_q  <= '0;
      stall_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      stall_q <= stall_d;
    end
  end
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < STAGES; i++) occupancy = occupancy + OCCW'(valid_q[i]);
  end
  assign in_allowin  = allowin[0];
  assign out_valid   = go[STAGES-1];
  assign out_data    = data_q[(STAGES-1)*WIDTH +: WIDTH];
  assign stage_valid = valid_q;
  assign stage_data  = data_q;
  assign stall_cnt   = stall_q;
endmodule

// File: tb/tb_pipe_valid_chain.sv
// tb_pipe_valid_chain: directed checks of the valid/allowin pipeline with a 4-bit stall counter
module tb_pipe_valid_chain;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_allowin;
  logic [7:0]  in_data = '0;
  logic [4:0]  stage_hold = '0;
  logic [4:0]  flush_mask = '0;
  logic        out_valid;
  logic        out_allowin = 1'b1;
  logic [7:0]  out_data;
  logic [4:0]  stage_valid;
  logic [39:0] stage_data;
  logic [2:0]  occupancy;
  logic [3:0]  stall_cnt;
  int errors = 0;
  int checks = 0;
  pipe_valid_chain #(.STAGES(5), .WIDTH(8), .CNTW(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_allowin(in_allowin),
    .in_data(in_data), .stage_hold(stage_hold), .flush_mask(flush_mask),
    .out_valid(out_valid), .out_allowin(out_allowin), .out_data(out_data),
    .stage_valid(stage_valid), .stage_data(stage_data), .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    stage_hold = '0; flush_mask = '0; out_allowin = 1'b1;
    step();
    reset = 1'b0;
  endtask
  initial begin
    do_reset();
    step();
    chk("rst_valid", stage_valid, 5'b0);
    chk("rst_data", stage_data, 40'h0);
    chk("rst_stall", stall_cnt, 4'd0);
    chk("rst_allowin", in_allowin, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_occ", occupancy, 3'd0);
    // T1: streaming, first item out after 5 edges
    in_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_data = 8'(k);
      step();
      chk("t1_occ", occupancy, (k < 5) ? k : 5);
      chk("t1_out_valid", out_valid, k >= 5);
      if (k >= 5) chk("t1_out_data", out_data, k - 4);
    end
    chk("t1_stall", stall_cnt, 4'd0);
    // T2: hold stage 2 for 3 cycles on a full pipe holding 8,7,6,5,4
    in_data = 8'd9;
    stage_hold = 5'b00100;
    for (int c = 1; c <= 3; c++) begin
      #1;
      chk("t2_in_allowin", in_allowin, 1'b0);
      step();
      chk("t2_bubble", stage_valid[3], 1'b0);
      chk("t2_frozen", stage_data[23:0], 24'h060708);
    end
    chk("t2_valid", stage_valid, 5'b00111);
    chk("t2_stall", stall_cnt, 4'd3);
    stage_hold = '0;
    #1;
    chk("t2_release", in_allowin, 1'b1);
    // T3: back-pressure for 10 cycles, then drain 1..5 exactly once
    do_reset();
    out_allowin = 1'b0;
    in_valid = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      in_data = (c <= 5) ? 8'(c) : 8'd6;
      step();
      chk("t3_occ", occupancy, (c < 5) ? c : 5);
      if (c >= 5) chk("t3_in_allowin", in_allowin, 1'b0);
    end
    chk("t3_stall", stall_cnt, 4'd5);
    in_valid = 1'b0;
    out_allowin = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      #1;
      chk("t3_out_valid", out_valid, 1'b1);
      chk("t3_out_data", out_data, k);
      step();
    end
    chk("t3_empty", out_valid, 1'b0);
    // T4: flush the two youngest of 10..14
    do_reset();
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data = 8'(10 + k);
      step();
    end
    chk("t4_full", stage_data, 40'h0a0b0c0d0e);
    in_valid = 1'b0;
    out_allowin = 1'b0;
    flush_mask = 5'b00011;
    #1;
    chk("t4_flush_allowin", in_allowin, 1'b1);
    step();
    flush_mask = '0;
    chk("t4_occ", occupancy, 3'd3);
    chk("t4_valid", stage_valid, 5'b11100);
    out_allowin = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_out_data", out_data, 10 + k);
      step();
    end
    chk("t4_drained", out_valid, 1'b0);
    chk("t4_occ_end", occupancy, 3'd0);
    // T5: flush and hold together on stage 1
    do_reset();
    in_valid = 1'b1;
    in_data = 8'd20;
    step();
    in_data = 8'd21;
    step();
    chk("t5_pre", stage_valid, 5'b00011);
    in_data = 8'd22;
    stage_hold = 5'b00010;
    flush_mask = 5'b00010;
    #1;
    chk("t5_allowin", in_allowin, 1'b1);
    step();
    stage_hold = '0;
    flush_mask = '0;
    in_valid = 1'b0;
    chk("t5_emptied", stage_valid, 5'b00001);
    chk("t5_s0", stage_data[7:0], 8'd22);
    step();
    chk("t5_advanced", stage_valid, 5'b00010);
    chk("t5_s1", stage_data[15:8], 8'd22);
    // T6: saturate the 4-bit stall counter, then reset mid-stream
    do_reset();
    out_allowin = 1'b0;
    in_valid = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      in_data = 8'(c);
      step();
      if (c == 10) chk("t6_stall_mid", stall_cnt, 4'd5);
      if (c == 20) chk("t6_stall_sat", stall_cnt, 4'd15);
    end
    chk("t6_stall_hold", stall_cnt, 4'd15);
    chk("t6_occ_full", occupancy, 3'd5);
    reset = 1'b1;
    step();
    chk("t6_rst_valid", stage_valid, 5'b0);
    chk("t6_rst_stall", stall_cnt, 4'd0);
    chk("t6_rst_out_valid", out_valid, 1'b0);
    chk("t6_rst_allowin", in_allowin, 1'b1);
    reset = 1'b0;
    in_valid = 1'b0;
    step();
    chk("t6_after", occupancy, 3'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
